// File: rtl/rv32_data_bus_ctrl.sv
// rtl/rv32_data_bus_ctrl.sv - data-side bus sequencer: decode, single-target request, response pulse
module rv32_data_bus_ctrl #(
    parameter int          NUM_MMIO         = 2,
    parameter logic [31:0] MEM_BASE         = 32'h0000_0000,
    parameter logic [31:0] MMIO_BASE        = 32'h8000_0000,
    parameter int          MMIO_STRIDE_LOG2 = 12,
    parameter int          TIMEOUT          = 255
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     core_req_valid,
    input  logic [31:0]              core_req_addr,
    input  logic                     core_req_we,
    input  logic [31:0]              core_req_wdata,
    input  logic [3:0]               core_req_wstrb,
    output logic                     core_req_ready,
    output logic                     core_resp_valid,
    output logic [31:0]              core_resp_data,
    output logic                     core_resp_err,
    output logic [31:0]              tgt_addr,
    output logic                     tgt_we,
    output logic [31:0]              tgt_wdata,
    output logic [3:0]               tgt_wstrb,
    output logic                     mem_req_valid,
    input  logic                     mem_done,
    input  logic [31:0]              mem_rdata,
    output logic [NUM_MMIO-1:0]      mmio_req_valid,
    input  logic [NUM_MMIO-1:0]      mmio_done,
    input  logic [NUM_MMIO-1:0][31:0] mmio_rdata,
    output logic                     spurious_done
);
    localparam int          IDXW     = (NUM_MMIO > 1) ? $clog2(NUM_MMIO) : 1;
    localparam logic [32:0] MMIO_END = {1'b0, MMIO_BASE} + (33'(NUM_MMIO) << MMIO_STRIDE_LOG2);
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_ERR} state_t;

    state_t            state, state_nxt;
    logic              sel_mem;
    logic [IDXW-1:0]   sel_idx;
    logic [15:0]       cnt;
    logic              dec_mem, dec_mmio;
    logic [IDXW-1:0]   dec_idx;
    logic              sel_done;
    logic [31:0]       sel_rdata;
    logic              spurious_evt;

    // MEM is checked first so it wins when the two regions overlap
    always_comb begin
        dec_mem  = (core_req_addr[31:28] == MEM_BASE[31:28]);
        dec_mmio = ({1'b0, core_req_addr} >= {1'b0, MMIO_BASE}) && ({1'b0, core_req_addr} < MMIO_END);
        dec_idx  = IDXW'((core_req_addr - MMIO_BASE) >> MMIO_STRIDE_LOG2);
    end

    assign sel_done  = sel_mem ? mem_done : mmio_done[sel_idx];
    assign sel_rdata = sel_mem ? mem_rdata : mmio_rdata[sel_idx];

    // Any done not matched by a live request strobe is spurious
    assign spurious_evt = (mem_done && !mem_req_valid) || (|(mmio_done & ~mmio_req_valid));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        core_req_ready  = 1'b0;
        core_resp_valid = 1'b0;
        core_resp_err   = 1'b0;
        core_resp_data  = 32'h0;
        mem_req_valid   = 1'b0;
        mmio_req_valid  = '0;
        case (state)
            S_IDLE: begin
                core_req_ready = 1'b1;
                if (core_req_valid) begin
                    state_nxt = (dec_mem || dec_mmio) ? S_WAIT : S_ERR;
                end
            end
            S_WAIT: begin
                mem_req_valid = sel_mem;
                for (int i = 0; i < NUM_MMIO; i++) begin
                    mmio_req_valid[i] = !sel_mem && (sel_idx == IDXW'(i));
                end
                if (sel_done) begin
                    state_nxt = S_RESP;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_ERR;
                end
            end
            S_RESP: begin
                core_resp_valid = 1'b1;
                core_resp_data  = tgt_we ? 32'h0 : sel_rdata;
                state_nxt       = S_IDLE;
            end
            S_ERR: begin
                core_resp_valid = 1'b1;
                core_resp_err   = 1'b1;
                state_nxt       = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tgt_addr      <= 32'h0;
            tgt_we        <= 1'b0;
            tgt_wdata     <= 32'h0;
            tgt_wstrb     <= 4'h0;
            sel_mem       <= 1'b0;
            sel_idx       <= '0;
            cnt           <= 16'h0;
            spurious_done <= 1'b0;
        end else begin
            if (state == S_IDLE && core_req_valid) begin
                tgt_addr  <= core_req_addr;
                tgt_we    <= core_req_we;
                tgt_wdata <= core_req_wdata;
                tgt_wstrb <= core_req_wstrb;
                sel_mem   <= dec_mem;
                sel_idx   <= dec_mem ? '0 : dec_idx;
                cnt       <= 16'h0;
            end else if (state == S_WAIT) begin
                cnt <= cnt + 16'd1;
            end
            if (spurious_evt) begin
                spurious_done <= 1'b1;
            end
        end
    end
endmodule
